// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - core register file defaults, register indices and decode address type
package regfile_pkg;

  localparam int REGFILE_WIDTH  = 8;
  localparam int REGFILE_DEPTH  = 8;
  localparam int REGFILE_ADDR_W = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R0 = 3'd0;
  localparam reg_addr_t R1 = 3'd1;
  localparam reg_addr_t R2 = 3'd2;
  localparam reg_addr_t R3 = 3'd3;
  localparam reg_addr_t R4 = 3'd4;
  localparam reg_addr_t R5 = 3'd5;
  localparam reg_addr_t R6 = 3'd6;
  localparam reg_addr_t R7 = 3'd7;

  // Depth need not be a power of two, so some encodable addresses name no entry.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// rtl/regfile_cell.sv - WIDTH-bit storage cell with synchronous active-low clear and load enable
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = d;
    end
  end

  // Clear wins over load in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - DEPTH x WIDTH register file, one synchronous write port, two combinational reads
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to both read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  // A write is real only if it targets an existing, non-hardwired entry.
  always_comb begin
    wr_ok = we && addr_in_range(32'(waddr), DEPTH) && !((ZERO_REG != 0) && (waddr == '0));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_cell
      regfile_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .load(wr_ok && (waddr == ADDR_W'(i))),
        .d   (wdata),
        .q   (mem[i])
      );
    end
  end

  always_comb begin
    rdata_a = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (raddr_a == ADDR_W'(k)) begin
        rdata_a = mem[k];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_ok && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
`endif
  end

  always_comb begin
    rdata_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (raddr_b == ADDR_W'(k)) begin
        rdata_b = mem[k];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_ok && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - vector table, corner sequences and random checks for regfile_2r1w
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic [2:0] raddr_a = 3'd0;
  logic [2:0] raddr_b = 3'd0;
  logic [7:0] rd_a [3];
  logic [7:0] rd_b [3];

  always #5 clk = ~clk;

  // 0: 8 deep with zero reg, 1: 8 deep ordinary entry 0, 2: 6 deep with zero reg
  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a[0]), .raddr_b(raddr_b), .rdata_b(rd_b[0]));
  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a[1]), .raddr_b(raddr_b), .rdata_b(rd_b[1]));
  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) dut6 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a[2]), .raddr_b(raddr_b), .rdata_b(rd_b[2]));

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m [3][8];
  int dep [3] = '{8, 8, 6};
  bit zr  [3] = '{1'b1, 1'b0, 1'b1};

  function automatic bit writable(int k);
    return we && (int'(waddr) < dep[k]) && !(zr[k] && waddr == 3'd0);
  endfunction

  function automatic logic [7:0] exp_read(int k, logic [2:0] a);
    if (int'(a) >= dep[k]) return 8'h00;
    if (zr[k] && a == 3'd0) return 8'h00;
    if (BYP && rst && writable(k) && a == waddr) return wdata;
    return m[k][a];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_dut%0d_a", tag, k), rd_a[k], exp_read(k, raddr_a));
      chk($sformatf("%s_dut%0d_b", tag, k), rd_b[k], exp_read(k, raddr_b));
    end
  endtask

  task automatic edge_update();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        for (int e = 0; e < 8; e++) m[k][e] = 8'h00;
      end else if (writable(k)) begin
        m[k][waddr] = wdata;
      end
    end
  endtask

  typedef struct {
    logic       r;
    logic       w;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic w, logic [2:0] wa, logic [7:0] wd,
                              logic [2:0] ra, logic [2:0] rb, logic [7:0] ea, logic [7:0] eb);
    vec_t v;
    v.r = r; v.w = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic logic [7:0] byp(logic [7:0] fwd, logic [7:0] old);
    return BYP ? fwd : old;
  endfunction

  initial begin
    // Expectations for dut (8 deep, zero reg) sampled before each row's edge.
    tbl[0] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd7, 8'h00, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      tbl[i] = mk(1'b1, 1'b1, 3'(i), 8'(8'hA0 + i), 3'(i), 3'd0, byp(8'(8'hA0 + i), 8'h00), 8'h00);
    end
    tbl[8]  = mk(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA3, 8'hA7);
    tbl[9]  = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h00, 8'h00);
    tbl[10] = mk(1'b1, 1'b1, 3'd3, 8'h5C, 3'd3, 3'd6, byp(8'h5C, 8'h00), 8'h00);
    tbl[11] = mk(1'b1, 1'b1, 3'd6, 8'h3A, 3'd3, 3'd6, 8'h5C, byp(8'h3A, 8'h00));
    tbl[12] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6, 8'h5C, 8'h3A);
    tbl[13] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h5C, 8'h5C);
    tbl[14] = mk(1'b1, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'h5C);
    tbl[15] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd6, 8'h00, 8'h3A);
    tbl[16] = mk(1'b1, 1'b1, 3'd4, 8'h11, 3'd4, 3'd0, byp(8'h11, 8'h00), 8'h00);
    tbl[17] = mk(1'b1, 1'b1, 3'd4, 8'h22, 3'd4, 3'd4, byp(8'h22, 8'h11), byp(8'h22, 8'h11));
    tbl[18] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h22, 8'h5C);
    tbl[19] = mk(1'b0, 1'b1, 3'd2, 8'h77, 3'd2, 3'd4, 8'h00, 8'h22);
    tbl[20] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 8'h00, 8'h00);
    tbl[21] = mk(1'b1, 1'b1, 3'd7, 8'h99, 3'd7, 3'd5, byp(8'h99, 8'h00), 8'h00);
    tbl[22] = mk(1'b1, 1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 8'h99, 8'h00);

    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    edge_update();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
      check_model($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_a", i), rd_a[0], tbl[i].ea);
      chk($sformatf("vec%0d_b", i), rd_b[0], tbl[i].eb);
      edge_update();
    end

    // Entry 0 write: hardwired zero versus ordinary entry.
    drive(1'b1, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd1);
    edge_update();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
    chk("zero_reg_r0", rd_a[0], 8'h00);
    chk("plain_r0", rd_a[1], 8'hFF);
    edge_update();

    // Six-deep instance: writes to 6 and 7 vanish, 5 survives.
    drive(1'b1, 1'b1, 3'd5, 8'h55, 3'd0, 3'd0);
    edge_update();
    drive(1'b1, 1'b1, 3'd7, 8'h99, 3'd0, 3'd0);
    edge_update();
    drive(1'b1, 1'b1, 3'd6, 8'h66, 3'd0, 3'd0);
    edge_update();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd6, 3'd7);
    chk("d6_addr6", rd_a[2], 8'h00);
    chk("d6_addr7", rd_b[2], 8'h00);
    chk("d8_addr6", rd_a[0], 8'h66);
    chk("d8_addr7", rd_b[0], 8'h99);
    check_model("oob");
    edge_update();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd5, 3'd4);
    chk("d6_addr5", rd_a[2], 8'h55);
    check_model("oob2");
    edge_update();

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", i));
      edge_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
